// File: rtl/bcd_display_controller.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with registered digits and a leading-zero blank mask for the display bank.
module bcd_display_controller #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = 4 * DIGITS;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [SW-1:0]     scratch_q, scratch_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [SW-1:0]     bcd_q, bcd_d;
   logic [DIGITS-1:0] blank_q, blank_d;

   logic [SW-1:0]       adjusted;
   logic [SW+WIDTH-1:0] shifted;
   logic                zero_run;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      blank_d   = blank_q;
      adjusted  = '0;
      shifted   = '0;
      zero_run  = 1'b1;

      // Add-3 is digit-local; a corrected digit never exceeds 12 so no carry is lost.
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         else
            adjusted[4*i +: 4] = scratch_q[4*i +: 4];
      end
      shifted = {adjusted, shift_q} << 1;

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d   = bin;
               scratch_d = '0;
               cnt_d     = CW'(WIDTH);
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = shifted[SW+WIDTH-1:WIDTH];
            shift_d   = shifted[WIDTH-1:0];
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d      = shifted[SW+WIDTH-1:WIDTH];
               blank_d[0] = 1'b0;
               // Blank a position only while every more-significant digit is zero too.
               for (int i = DIGITS - 1; i >= 1; i--) begin
                  zero_run   = zero_run && (shifted[WIDTH + 4*i +: 4] == 4'd0);
                  blank_d[i] = zero_run;
               end
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign bcd   = bcd_q;
   assign blank = blank_q;

endmodule

// File: tb/tb_bcd_display_controller.sv
// Directed testbench for bcd_display_controller: latency, digit values,
// blank mask, ignored starts, back-to-back throughput and mid-run reset.
module tb_bcd_display_controller;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] bin;
   logic        busy;
   logic        done;
   logic [19:0] bcd;
   logic [4:0]  blank;

   int checks = 0;
   int errors = 0;

   bcd_display_controller #(.WIDTH(16), .DIGITS(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .blank (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      checks++;
      if (busy && done) begin
         errors++;
         $display("[TB] FAIL busy_done_overlap: busy=%b done=%b, required not both high", busy, done);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a one-cycle start and returns edges from the start edge to done.
   task automatic run_conv(input logic [15:0] v, output int lat);
      start = 1'b1;
      bin   = v;
      tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      bin   = 16'd77;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000 || blank !== 5'b11110) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b done=%b bcd=%h blank=%b, required 0 0 00000 11110",
                     busy, done, bcd, blank);
         end
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_no_start: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_values();
      logic [15:0] vin   [4] = '{16'd0, 16'd65535, 16'd1234, 16'd100};
      logic [19:0] vbcd  [4] = '{20'h00000, 20'h65535, 20'h01234, 20'h00100};
      logic [4:0]  vblank[4] = '{5'b11110, 5'b00000, 5'b10000, 5'b11000};
      int lat;
      for (int k = 0; k < 4; k++) begin
         run_conv(vin[k], lat);
         checks++;
         if (lat !== 16) begin
            errors++;
            $display("[TB] FAIL latency_%0d: got %0d cycles, required 16", vin[k], lat);
         end
         checks++;
         if (bcd !== vbcd[k] || blank !== vblank[k]) begin
            errors++;
            $display("[TB] FAIL value_%0d: bcd=%h blank=%b, required %h %b",
                     vin[k], bcd, blank, vbcd[k], vblank[k]);
         end
         tick();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_width_%0d: done=%b, required 0", vin[k], done);
         end
      end
   endtask

   task automatic test_ignore_start();
      int cyc = 0;
      int ndone = 0;
      start = 1'b1;
      bin   = 16'd4321;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_after_start: busy=%b, required 1", busy);
      end
      while (cyc < 30) begin
         start = (cyc == 3 || cyc == 10);
         bin   = (cyc >= 1) ? 16'd9 : 16'd4321;
         tick();
         cyc++;
         if (done) begin
            ndone++;
            checks++;
            if (cyc !== 16 || bcd !== 20'h04321 || blank !== 5'b10000) begin
               errors++;
               $display("[TB] FAIL ignore_start: cycle=%0d bcd=%h blank=%b, required 16 04321 10000",
                        cyc, bcd, blank);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (ndone !== 1 || bcd !== 20'h04321 || blank !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL ignore_hold: dones=%0d bcd=%h blank=%b, required 1 04321 10000",
                  ndone, bcd, blank);
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      int d1 = -1;
      int d2 = -1;
      start = 1'b1;
      bin   = 16'd42;
      tick();
      bin = 16'd7;
      while (cyc < 45) begin
         tick();
         cyc++;
         if (cyc == 18) start = 1'b0;
         if (done && d1 < 0) begin
            d1 = cyc;
            checks++;
            if (bcd !== 20'h00042 || blank !== 5'b11100) begin
               errors++;
               $display("[TB] FAIL b2b_first: bcd=%h blank=%b, required 00042 11100", bcd, blank);
            end
         end else if (done && d2 < 0) begin
            d2 = cyc;
            checks++;
            if (bcd !== 20'h00007 || blank !== 5'b11110) begin
               errors++;
               $display("[TB] FAIL b2b_second: bcd=%h blank=%b, required 00007 11110", bcd, blank);
            end
         end
      end
      checks++;
      if (d1 !== 16 || d2 - d1 !== 17) begin
         errors++;
         $display("[TB] FAIL b2b_spacing: first=%0d gap=%0d, required 16 17", d1, d2 - d1);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int lat;
      start = 1'b1;
      bin   = 16'd999;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000 || blank !== 5'b11110) begin
         errors++;
         $display("[TB] FAIL mid_reset_state: busy=%b done=%b bcd=%h blank=%b, required 0 0 00000 11110",
                  busy, done, bcd, blank);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL mid_reset_abort: activity cycles=%0d, required 0", seen);
      end
      run_conv(16'd999, lat);
      checks++;
      if (lat !== 16 || bcd !== 20'h00999 || blank !== 5'b11000) begin
         errors++;
         $display("[TB] FAIL mid_reset_rerun: lat=%0d bcd=%h blank=%b, required 16 00999 11000",
                  lat, bcd, blank);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      bin   = 16'd0;
      #2;
      test_reset();
      test_values();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
